// File: rtl/mem_arbiter_if.sv
// Bundle of fetch-port, data-port and memory-port signals around mem_arbiter.
// slave = the arbiter; master = the requesting stages plus the memory.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;
    logic              if_stall;

    logic              dm_req;
    logic              dm_wr;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ready;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_stall;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd;
    logic              mem_wr;
    logic              mem_busy;
    logic              mem_done;
    logic [DATA_W-1:0] mem_rdata;

    logic              err;

    modport slave (
        input  if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata,
        input  mem_busy, mem_done, mem_rdata,
        output if_ready, if_rdata, if_stall, dm_ready, dm_rdata, dm_stall,
        output mem_addr, mem_wdata, mem_rd, mem_wr, err
    );

    modport master (
        output if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata,
        output mem_busy, mem_done, mem_rdata,
        input  if_ready, if_rdata, if_stall, dm_ready, dm_rdata, dm_stall,
        input  mem_addr, mem_wdata, mem_rd, mem_wr, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port multi-cycle memory between fetch (IF) and data (DM).
// DM has priority, but after STARVE_MAX DM grants with fetch waiting, IF wins.
module mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int STREAK_W = $clog2(STARVE_MAX + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ISSUE_IF = 3'd1;
    localparam logic [2:0] S_ISSUE_DM = 3'd2;
    localparam logic [2:0] S_WAIT_IF  = 3'd3;
    localparam logic [2:0] S_WAIT_DM  = 3'd4;
    localparam logic [2:0] S_RESP     = 3'd5;

    logic [2:0]          state_reg, state_next;
    logic                owner_dm_reg;
    logic                wr_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [DATA_W-1:0]   if_rdata_reg;
    logic [DATA_W-1:0]   dm_rdata_reg;
    logic [STREAK_W-1:0] streak_reg;
    logic                err_reg;

    logic starved;
    logic if_wins;
    logic grant;
    logic in_wait;

    assign starved = (streak_reg == STREAK_W'(STARVE_MAX));
    assign if_wins = bus.if_req && (!bus.dm_req || starved);
    assign grant   = (state_reg == S_IDLE) && (bus.if_req || bus.dm_req);
    assign in_wait = (state_reg == S_WAIT_IF) || (state_reg == S_WAIT_DM);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:     if (bus.if_req || bus.dm_req)
                            state_next = if_wins ? S_ISSUE_IF : S_ISSUE_DM;
            S_ISSUE_IF: if (!bus.mem_busy) state_next = S_WAIT_IF;
            S_ISSUE_DM: if (!bus.mem_busy) state_next = S_WAIT_DM;
            S_WAIT_IF:  if (bus.mem_done)  state_next = S_RESP;
            S_WAIT_DM:  if (bus.mem_done)  state_next = S_RESP;
            S_RESP:     state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            owner_dm_reg <= 1'b0;
            wr_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            if_rdata_reg <= '0;
            dm_rdata_reg <= '0;
            streak_reg   <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (grant) begin
                owner_dm_reg <= !if_wins;
                if (if_wins) begin
                    addr_reg   <= bus.if_addr;
                    wr_reg     <= 1'b0;
                    streak_reg <= '0;
                end else begin
                    addr_reg  <= bus.dm_addr;
                    wdata_reg <= bus.dm_wdata;
                    wr_reg    <= bus.dm_wr;
                    // The streak only measures DM grants that made fetch wait.
                    if (!bus.if_req)
                        streak_reg <= '0;
                    else if (!starved)
                        streak_reg <= streak_reg + STREAK_W'(1);
                end
            end
            if (bus.mem_done && state_reg == S_WAIT_IF)
                if_rdata_reg <= bus.mem_rdata;
            if (bus.mem_done && state_reg == S_WAIT_DM && !wr_reg)
                dm_rdata_reg <= bus.mem_rdata;
            if (bus.mem_done && !in_wait)
                err_reg <= 1'b1;
        end
    end

    assign bus.mem_rd    = (state_reg == S_ISSUE_IF) || ((state_reg == S_ISSUE_DM) && !wr_reg);
    assign bus.mem_wr    = (state_reg == S_ISSUE_DM) && wr_reg;
    assign bus.mem_addr  = addr_reg;
    assign bus.mem_wdata = wdata_reg;
    assign bus.if_ready  = (state_reg == S_RESP) && !owner_dm_reg;
    assign bus.dm_ready  = (state_reg == S_RESP) && owner_dm_reg;
    assign bus.if_rdata  = if_rdata_reg;
    assign bus.dm_rdata  = dm_rdata_reg;
    assign bus.if_stall  = bus.if_req && !bus.if_ready;
    assign bus.dm_stall  = bus.dm_req && !bus.dm_ready;
    assign bus.err       = err_reg;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: requester driver, memory model and a scoreboard of
// expected commands/responses, fed from a vector table and hand-built sequences.
module tb_mem_arbiter;
    typedef struct {
        bit          is_dm;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          busy;
        int          delay;
        logic [15:0] mdata;
        logic [15:0] exp;
        int          lat;
        int          stl;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();
    mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   model_en = 1'b1;
    bit   drv_en   = 1'b1;
    bit   mon_en   = 1'b1;
    txn_t sb[$];
    txn_t if_list[$];
    txn_t dm_list[$];
    int   if_t0q[$];
    int   dm_t0q[$];
    txn_t vec[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic txn_t mk(input bit is_dm, input bit wr, input logic [15:0] addr,
                                input logic [15:0] wdata, input int busy, input int delay,
                                input logic [15:0] mdata, input logic [15:0] exp,
                                input int lat, input int stl);
        txn_t t;
        t.is_dm = is_dm; t.wr = wr; t.addr = addr; t.wdata = wdata;
        t.busy = busy; t.delay = delay; t.mdata = mdata; t.exp = exp;
        t.lat = lat; t.stl = stl;
        return t;
    endfunction

    task automatic req_push(input txn_t t);
        if (t.is_dm) dm_list.push_back(t);
        else         if_list.push_back(t);
    endtask

    task automatic wait_drain(input int limit);
        int  n;
        bit  done;
        n = 0;
        done = (sb.size() == 0) && (if_list.size() == 0) && (dm_list.size() == 0)
               && !bus.if_req && !bus.dm_req;
        while (!done && n < limit) begin
            @(negedge clk); #3;
            n++;
            done = (sb.size() == 0) && (if_list.size() == 0) && (dm_list.size() == 0)
                   && !bus.if_req && !bus.dm_req;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
            sb.delete(); if_list.delete(); dm_list.delete();
            if_t0q.delete(); dm_t0q.delete();
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Memory model: busy/latency/read data come from the outstanding scoreboard entry.
    initial begin : mem_model
        int          bcnt, dcnt, cb, cd;
        bit          waiting;
        logic [15:0] cm;
        bcnt = 0; dcnt = 0; waiting = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bcnt = 0; dcnt = 0; waiting = 1'b0;
            end
            if (model_en) begin
                cb = 0; cd = 0; cm = 16'h0BAD;
                if (sb.size() != 0) begin
                    cb = sb[0].busy; cd = sb[0].delay; cm = sb[0].mdata;
                end
                bus.mem_done  = 1'b0;
                bus.mem_rdata = 16'h0BAD;
                bus.mem_busy  = 1'b0;
                if (rst) begin
                    bus.mem_busy = 1'b0;
                end else if (waiting) begin
                    if (dcnt >= cd) begin
                        bus.mem_done  = 1'b1;
                        bus.mem_rdata = cm;
                        waiting = 1'b0;
                        bcnt = 0;
                    end else begin
                        dcnt++;
                    end
                end else if (bus.mem_rd || bus.mem_wr) begin
                    if (bcnt < cb) begin
                        bus.mem_busy = 1'b1;
                        bcnt++;
                    end else begin
                        waiting = 1'b1;
                        dcnt = 0;
                    end
                end
            end
        end
    end

    // Requesters: hold each request until its ready, then present the next or drop.
    initial begin : driver
        bit   if_act, dm_act;
        txn_t t;
        if_act = 1'b0; dm_act = 1'b0;
        forever begin
            @(negedge clk); #1;
            if (drv_en && !rst) begin
                if (if_act && bus.if_ready) begin
                    if_act = 1'b0; bus.if_req = 1'b0;
                end
                if (!if_act && if_list.size() != 0) begin
                    t = if_list.pop_front();
                    bus.if_req = 1'b1; bus.if_addr = t.addr;
                    if_act = 1'b1; if_t0q.push_back(cyc);
                end
                if (dm_act && bus.dm_ready) begin
                    dm_act = 1'b0; bus.dm_req = 1'b0;
                end
                if (!dm_act && dm_list.size() != 0) begin
                    t = dm_list.pop_front();
                    bus.dm_req = 1'b1; bus.dm_wr = t.wr;
                    bus.dm_addr = t.addr; bus.dm_wdata = t.wdata;
                    dm_act = 1'b1; dm_t0q.push_back(cyc);
                end
            end
        end
    end

    // Scoreboard: commands compared every cycle they are asserted, responses at ready.
    initial begin : monitor
        int          if_st, dm_st, cmdc, t0, st;
        logic [15:0] exp_if_rd, exp_dm_rd;
        txn_t        e;
        if_st = 0; dm_st = 0; cmdc = 0;
        exp_if_rd = 16'h0; exp_dm_rd = 16'h0;
        forever begin
            @(negedge clk); #2;
            if (!rst && mon_en) begin
                if (bus.if_stall) if_st++;
                if (bus.dm_stall) dm_st++;
                if (bus.mem_rd || bus.mem_wr) begin
                    if (sb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL cmd_unexpected: rd=%0b wr=%0b addr=%0h with nothing outstanding",
                                 bus.mem_rd, bus.mem_wr, bus.mem_addr);
                    end else begin
                        cmdc++;
                        chk("mem_addr", 32'(bus.mem_addr), 32'(sb[0].addr));
                        chk("mem_wr", 32'(bus.mem_wr), 32'(sb[0].is_dm & sb[0].wr));
                        chk("mem_rd", 32'(bus.mem_rd), 32'(!(sb[0].is_dm & sb[0].wr)));
                        if (sb[0].is_dm && sb[0].wr)
                            chk("mem_wdata", 32'(bus.mem_wdata), 32'(sb[0].wdata));
                    end
                end
                if (bus.if_ready || bus.dm_ready) begin
                    if (sb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL ready_unexpected: if_ready=%0b dm_ready=%0b with nothing outstanding",
                                 bus.if_ready, bus.dm_ready);
                    end else begin
                        e = sb.pop_front();
                        chk("ready_port", 32'(bus.dm_ready), 32'(e.is_dm));
                        chk("ready_both", 32'(bus.if_ready & bus.dm_ready), 32'(0));
                        if (e.is_dm) begin
                            chk("dm_rdata", 32'(bus.dm_rdata), 32'(e.exp));
                            chk("if_rdata_hold", 32'(bus.if_rdata), 32'(exp_if_rd));
                            exp_dm_rd = e.exp;
                            t0 = (dm_t0q.size() != 0) ? dm_t0q.pop_front() : cyc;
                            st = dm_st; dm_st = 0;
                        end else begin
                            chk("if_rdata", 32'(bus.if_rdata), 32'(e.exp));
                            chk("dm_rdata_hold", 32'(bus.dm_rdata), 32'(exp_dm_rd));
                            exp_if_rd = e.exp;
                            t0 = (if_t0q.size() != 0) ? if_t0q.pop_front() : cyc;
                            st = if_st; if_st = 0;
                        end
                        $display("txn %s addr=%04h wr=%0b rdata_exp=%04h latency=%0d stall=%0d cmd_cycles=%0d",
                                 e.is_dm ? "DM" : "IF", e.addr, e.wr, e.exp, cyc - t0, st, cmdc);
                        chk("latency", 32'(cyc - t0), 32'(e.lat));
                        chk("stall_cycles", 32'(st), 32'(e.stl));
                        chk("cmd_cycles", 32'(cmdc), 32'(e.busy + 1));
                        cmdc = 0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin : main
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_req = 1'b0; bus.dm_wr = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
        bus.mem_busy = 1'b0; bus.mem_done = 1'b0; bus.mem_rdata = '0;

        //           dm wr addr      wdata     b  d  mdata     exp
        vec[0] = mk(0, 0, 16'h0040, 16'h0000, 0, 2, 16'h1234, 16'h1234, 0, 0);
        vec[1] = mk(1, 0, 16'h0300, 16'h0000, 0, 0, 16'hCAFE, 16'hCAFE, 0, 0);
        vec[2] = mk(1, 1, 16'h0100, 16'hBEEF, 0, 1, 16'hDEAD, 16'hCAFE, 0, 0);
        vec[3] = mk(1, 0, 16'h0200, 16'h0000, 2, 0, 16'h0F0F, 16'h0F0F, 0, 0);
        vec[4] = mk(0, 0, 16'h0042, 16'h0000, 1, 1, 16'hA5A5, 16'hA5A5, 0, 0);
        vec[5] = mk(1, 1, 16'hFFFF, 16'h0001, 1, 0, 16'h5555, 16'h0F0F, 0, 0);
        for (int i = 0; i < 6; i++) begin
            vec[i].lat = 3 + vec[i].busy + vec[i].delay;
            vec[i].stl = vec[i].lat;
        end

        repeat (3) @(negedge clk);
        #1;
        chk("rst_if_ready", 32'(bus.if_ready), 32'(0));
        chk("rst_dm_ready", 32'(bus.dm_ready), 32'(0));
        chk("rst_mem_rd", 32'(bus.mem_rd), 32'(0));
        chk("rst_mem_wr", 32'(bus.mem_wr), 32'(0));
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'(0));
        chk("rst_if_rdata", 32'(bus.if_rdata), 32'(0));
        chk("rst_dm_rdata", 32'(bus.dm_rdata), 32'(0));
        chk("rst_err", 32'(bus.err), 32'(0));
        rst = 1'b0;
        @(negedge clk); #3;

        for (int i = 0; i < 6; i++) begin
            sb.push_back(vec[i]);
            req_push(vec[i]);
            wait_drain(100);
        end

        // Simultaneous requests: DM first, IF issued only after DM's RESP/IDLE.
        begin
            txn_t d, f;
            d = mk(1, 0, 16'h0200, 16'h0000, 0, 0, 16'h7777, 16'h7777, 3, 3);
            f = mk(0, 0, 16'h0044, 16'h0000, 0, 0, 16'h1111, 16'h1111, 7, 7);
            sb.push_back(d); sb.push_back(f);
            req_push(d); req_push(f);
            wait_drain(100);
        end

        // Starvation: four DM grants, then IF, then DM resumes.
        begin
            txn_t d[6];
            txn_t f;
            for (int i = 0; i < 6; i++)
                d[i] = mk(1, 0, 16'h1000 + 16'(i), 16'h0000, 0, 0, 16'h2000 + 16'(i),
                          16'h2000 + 16'(i), 4, 3);
            d[0].lat = 3;
            d[4].lat = 8; d[4].stl = 7;
            f = mk(0, 0, 16'h0050, 16'h0000, 0, 0, 16'h3333, 16'h3333, 19, 19);
            for (int i = 0; i < 4; i++) sb.push_back(d[i]);
            sb.push_back(f);
            sb.push_back(d[4]); sb.push_back(d[5]);
            for (int i = 0; i < 6; i++) req_push(d[i]);
            req_push(f);
            wait_drain(200);
        end

        chk("err_clean", 32'(bus.err), 32'(0));

        // Reset in WAIT_IF, then a late mem_done one cycle after release.
        mon_en = 1'b0; drv_en = 1'b0; model_en = 1'b0;
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 16'h0077;
        bus.mem_busy = 1'b0; bus.mem_done = 1'b0;
        @(negedge clk); #1;
        chk("rstseq_issue_rd", 32'(bus.mem_rd), 32'(1));
        @(negedge clk); #1;
        chk("rstseq_wait_rd", 32'(bus.mem_rd), 32'(0));
        rst = 1'b1;
        #1;
        chk("midrst_mem_rd", 32'(bus.mem_rd), 32'(0));
        chk("midrst_mem_addr", 32'(bus.mem_addr), 32'(0));
        chk("midrst_mem_wdata", 32'(bus.mem_wdata), 32'(0));
        chk("midrst_if_rdata", 32'(bus.if_rdata), 32'(0));
        chk("midrst_dm_rdata", 32'(bus.dm_rdata), 32'(0));
        chk("midrst_if_ready", 32'(bus.if_ready), 32'(0));
        bus.if_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.mem_done = 1'b1; bus.mem_rdata = 16'h4444;
        @(negedge clk);
        bus.mem_done = 1'b0;
        #1;
        chk("late_done_err", 32'(bus.err), 32'(1));
        for (int i = 0; i < 3; i++) begin
            chk("late_done_no_ready", 32'({bus.if_ready, bus.dm_ready}), 32'(0));
            chk("late_done_if_rdata", 32'(bus.if_rdata), 32'(0));
            @(negedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
